// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM port arbiter.
// Holds the default address/data widths, the requester ID type and the
// largest supported BRAM read latency.
package bram_pkg;

   localparam int unsigned ADDR_W_DEF       = 16;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned MAX_READ_LATENCY = 4;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   function automatic req_id_t other_req(input req_id_t id);
      return (id == REQ_A) ? REQ_B : REQ_A;
   endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Read-tag delay line for the BRAM port arbiter.
// Carries a {valid, owner} tag for each issued read, DEPTH cycles deep, so
// the returning BRAM data can be steered to the requester that asked for it.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears tags)
//   in_valid, in_owner  tag entering the pipe
//   out_valid, out_owner tag leaving the pipe DEPTH cycles later
module bram_rd_tag_pipe
   import bram_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    in_valid,
   input  req_id_t in_owner,
   output logic    out_valid,
   output req_id_t out_owner
);

   logic [DEPTH-1:0] valid_q;
   req_id_t          owner_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            owner_q[i] <= REQ_A;
         end
      end else begin
         valid_q[0] <= in_valid;
         owner_q[0] <= in_owner;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            owner_q[i] <= owner_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between requesters A and B.
// Grants are combinational; the BRAM port signals are registered one cycle
// after acceptance. Read data is steered back to the issuing requester after
// READ_LATENCY + 2 cycles from acceptance.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata        requester A access request
//   a_gnt                            A accepted this cycle (combinational)
//   a_rvalid/a_rdata                 read return pulse and data for A
//   b_*                              same set for requester B
//   pl_addr/pl_en/pl_wr_en/pl_din    registered BRAM port drive
//   pl_dout                          BRAM read data
module bram_port_arbiter
   import bram_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] pl_addr,
   output logic              pl_en,
   output logic              pl_wr_en,
   output logic [DATA_W-1:0] pl_din,
   input  logic [DATA_W-1:0] pl_dout
);

   req_id_t           ptr_q, ptr_d;
   req_id_t           owner_q, owner_d;
   logic              accept;
   req_id_t           sel;
   logic              en_d, wr_en_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] din_d;

   logic              tag_valid;
   req_id_t           tag_owner;

   // Grant and next-state for the pointer and the BRAM port registers.
   always_comb begin
      a_gnt   = a_req & (~b_req | (ptr_q == REQ_A));
      b_gnt   = b_req & (~a_req | (ptr_q == REQ_B));
      accept  = a_gnt | b_gnt;
      sel     = b_gnt ? REQ_B : REQ_A;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      en_d    = 1'b0;
      wr_en_d = 1'b0;
      addr_d  = pl_addr;
      din_d   = pl_din;
      if (accept) begin
         ptr_d   = other_req(sel);
         owner_d = sel;
         en_d    = 1'b1;
         wr_en_d = (sel == REQ_B) ? b_we : a_we;
         addr_d  = (sel == REQ_B) ? b_addr : a_addr;
         // Reads drive zero on the data bus.
         din_d   = wr_en_d ? ((sel == REQ_B) ? b_wdata : a_wdata) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q    <= REQ_A;
         owner_q  <= REQ_A;
         pl_en    <= 1'b0;
         pl_wr_en <= 1'b0;
         pl_addr  <= '0;
         pl_din   <= '0;
      end else begin
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         pl_en    <= en_d;
         pl_wr_en <= wr_en_d;
         pl_addr  <= addr_d;
         pl_din   <= din_d;
      end
   end

   // The tag enters from the registered port, so it emerges in the cycle
   // pl_dout carries the matching read data.
   bram_rd_tag_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pl_en & ~pl_wr_en),
      .in_owner  (owner_q),
      .out_valid (tag_valid),
      .out_owner (tag_owner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         a_rvalid <= tag_valid & (tag_owner == REQ_A);
         b_rvalid <= tag_valid & (tag_owner == REQ_B);
         if (tag_valid && tag_owner == REQ_A) a_rdata <= pl_dout;
         if (tag_valid && tag_owner == REQ_B) b_rdata <= pl_dout;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

   logic        clk;
   logic        rst;

   // Instance with READ_LATENCY = 1
   logic        a_req, a_we, a_gnt, a_rvalid;
   logic [15:0] a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic        b_req, b_we, b_gnt, b_rvalid;
   logic [15:0] b_addr;
   logic [31:0] b_wdata, b_rdata;
   logic [15:0] pl_addr;
   logic        pl_en, pl_wr_en;
   logic [31:0] pl_din, pl_dout;

   // Instance with READ_LATENCY = 3
   logic        xa_req, xa_we, xa_gnt, xa_rvalid;
   logic [15:0] xa_addr;
   logic [31:0] xa_wdata, xa_rdata;
   logic        xb_req, xb_we, xb_gnt, xb_rvalid;
   logic [15:0] xb_addr;
   logic [31:0] xb_wdata, xb_rdata;
   logic [15:0] xpl_addr;
   logic        xpl_en, xpl_wr_en;
   logic [31:0] xpl_din, xpl_dout;

   int errors = 0;
   int checks = 0;
   int a_cnt  = 0;
   int b_cnt  = 0;

   bram_port_arbiter #(
      .ADDR_W       (16),
      .DATA_W       (32),
      .READ_LATENCY (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a_req    (a_req),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_gnt    (a_gnt),
      .a_rvalid (a_rvalid),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_gnt    (b_gnt),
      .b_rvalid (b_rvalid),
      .b_rdata  (b_rdata),
      .pl_addr  (pl_addr),
      .pl_en    (pl_en),
      .pl_wr_en (pl_wr_en),
      .pl_din   (pl_din),
      .pl_dout  (pl_dout)
   );

   bram_port_arbiter #(
      .ADDR_W       (16),
      .DATA_W       (32),
      .READ_LATENCY (3)
   ) dut3 (
      .clk      (clk),
      .rst      (rst),
      .a_req    (xa_req),
      .a_we     (xa_we),
      .a_addr   (xa_addr),
      .a_wdata  (xa_wdata),
      .a_gnt    (xa_gnt),
      .a_rvalid (xa_rvalid),
      .a_rdata  (xa_rdata),
      .b_req    (xb_req),
      .b_we     (xb_we),
      .b_addr   (xb_addr),
      .b_wdata  (xb_wdata),
      .b_gnt    (xb_gnt),
      .b_rvalid (xb_rvalid),
      .b_rdata  (xb_rdata),
      .pl_addr  (xpl_addr),
      .pl_en    (xpl_en),
      .pl_wr_en (xpl_wr_en),
      .pl_din   (xpl_din),
      .pl_dout  (xpl_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first BRAM models; contents reloaded while reset is held.
   logic [31:0] mem1 [65536];
   logic [31:0] mem3 [65536];
   logic [31:0] s1;
   logic [31:0] s3 [3];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) mem1[i] <= 32'd100 + 32'(i);
         mem3[16'hFFFF] <= 32'hCAFE_F00D;
      end else begin
         if (pl_en && pl_wr_en) mem1[pl_addr] <= pl_din;
         if (xpl_en && xpl_wr_en) mem3[xpl_addr] <= xpl_din;
      end
      if (pl_en) s1 <= pl_wr_en ? pl_din : mem1[pl_addr];
      if (xpl_en) s3[0] <= xpl_wr_en ? xpl_din : mem3[xpl_addr];
      s3[1] <= s3[0];
      s3[2] <= s3[1];
   end

   assign pl_dout  = s1;
   assign xpl_dout = s3[2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      xa_req = 0; xa_we = 0; xa_addr = '0; xa_wdata = '0;
      xb_req = 0; xb_we = 0; xb_addr = '0; xb_wdata = '0;

      // Reset state
      tick();
      tick();
      @(negedge clk);
      chk("rst_pl_en", pl_en, 0);
      chk("rst_pl_wr_en", pl_wr_en, 0);
      chk("rst_pl_addr", pl_addr, 0);
      chk("rst_pl_din", pl_din, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      chk("rst_a_gnt", a_gnt, 0);
      tick();
      rst = 1'b0;

      // Idle for 10 cycles
      for (int c = 0; c < 10; c++) begin
         tick();
         @(negedge clk);
         chk("idle_pl_en", pl_en, 0);
         chk("idle_rvalid", {a_rvalid, b_rvalid}, 0);
      end

      // Lone A read stream, addresses 0..3
      for (int c = 0; c < 9; c++) begin
         tick();
         a_req  = (c < 4);
         a_we   = 1'b0;
         a_addr = (c < 4) ? 16'(c) : 16'h0;
         @(negedge clk);
         chk("str_a_gnt", a_gnt, (c < 4));
         chk("str_pl_en", pl_en, (c >= 1 && c <= 4));
         if (c >= 1 && c <= 4) begin
            chk("str_pl_addr", pl_addr, c - 1);
            chk("str_pl_wr_en", pl_wr_en, 0);
         end
         chk("str_a_rvalid", a_rvalid, (c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) chk("str_a_rdata", a_rdata, 100 + c - 3);
         chk("str_b_rvalid", b_rvalid, 0);
      end

      // Contention from reset
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 24; k++) begin
         tick();
         a_req  = (k < 20);
         b_req  = (k < 20);
         a_we   = 1'b0;
         b_we   = 1'b0;
         a_addr = 16'd1;
         b_addr = 16'd2;
         @(negedge clk);
         if (a_gnt) a_cnt++;
         if (b_gnt) b_cnt++;
         chk("con_a_gnt", a_gnt, (k < 20) && (k % 2 == 0));
         chk("con_b_gnt", b_gnt, (k < 20) && (k % 2 == 1));
         chk("con_pl_en", pl_en, (k >= 1 && k <= 20));
         chk("con_a_rvalid", a_rvalid, (k >= 3 && k <= 22) && ((k - 3) % 2 == 0));
         chk("con_b_rvalid", b_rvalid, (k >= 3 && k <= 22) && ((k - 3) % 2 == 1));
         if (a_rvalid) chk("con_a_rdata", a_rdata, 101);
         if (b_rvalid) chk("con_b_rdata", b_rdata, 102);
      end
      chk("con_a_count", a_cnt, 10);
      chk("con_b_count", b_cnt, 10);

      // B writes 0xDEADBEEF @0x10, then A reads 0x10
      tick();
      b_req = 1; b_we = 1; b_addr = 16'h0010; b_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr_b_gnt", b_gnt, 1);
      tick();
      b_req = 0; b_we = 0;
      a_req = 1; a_we = 0; a_addr = 16'h0010;
      @(negedge clk);
      chk("rd_a_gnt", a_gnt, 1);
      chk("wr_pl_en", pl_en, 1);
      chk("wr_pl_wr_en", pl_wr_en, 1);
      chk("wr_pl_addr", pl_addr, 16'h0010);
      chk("wr_pl_din", pl_din, 32'hDEAD_BEEF);
      tick();
      a_req = 0;
      @(negedge clk);
      chk("rd_pl_en", pl_en, 1);
      chk("rd_pl_wr_en", pl_wr_en, 0);
      chk("rd_pl_din", pl_din, 0);
      tick();
      @(negedge clk);
      chk("hold_pl_en", pl_en, 0);
      chk("hold_pl_addr", pl_addr, 16'h0010);
      chk("hold_pl_din", pl_din, 0);
      chk("raw_a_rvalid_early", a_rvalid, 0);
      chk("raw_b_rvalid", b_rvalid, 0);
      tick();
      @(negedge clk);
      chk("raw_a_rvalid", a_rvalid, 1);
      chk("raw_a_rdata", a_rdata, 32'hDEAD_BEEF);
      chk("raw_b_rdata_kept", b_rdata, 102);
      tick();
      @(negedge clk);
      chk("raw_a_rvalid_after", a_rvalid, 0);
      chk("raw_a_rdata_held", a_rdata, 32'hDEAD_BEEF);

      // READ_LATENCY = 3 instance, read @0xFFFF
      for (int c = 0; c < 8; c++) begin
         tick();
         xa_req  = (c == 0);
         xa_addr = 16'hFFFF;
         @(negedge clk);
         chk("lat3_a_gnt", xa_gnt, (c == 0));
         chk("lat3_pl_en", xpl_en, (c == 1));
         if (c == 1) chk("lat3_pl_addr", xpl_addr, 16'hFFFF);
         chk("lat3_a_rvalid", xa_rvalid, (c == 5));
         if (c == 5) chk("lat3_a_rdata", xa_rdata, 32'hCAFE_F00D);
         chk("lat3_b_rvalid", xb_rvalid, 0);
      end

      // Reset while a read is in flight
      tick();
      a_req = 1; a_we = 0; a_addr = 16'd0;
      @(negedge clk);
      chk("mid_a_gnt", a_gnt, 1);
      tick();
      a_req = 0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_pl_en_rst", pl_en, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_a_rvalid", a_rvalid, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clk);
         chk("mid_a_rvalid", a_rvalid, 0);
         chk("mid_a_rdata", a_rdata, 0);
      end
      tick();
      a_req = 1; b_req = 1;
      @(negedge clk);
      chk("mid_ptr_a_gnt", a_gnt, 1);
      chk("mid_ptr_b_gnt", b_gnt, 0);
      tick();
      a_req = 0; b_req = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single PL-side BRAM port between two requesters, A and B.
- Typical pairing: A is the address sequencer streaming reads; B is the result writer.
- Arbitration is round-robin. The block drives the BRAM port (address, enable, write enable, data in).
- Read data is returned to the requester that issued the read, after a fixed, parameterised BRAM read latency.

Parameters:
- ADDR_W, 16, BRAM address width.
- DATA_W, 32, BRAM data width.
- READ_LATENCY, 1, cycles from the cycle pl_en is high (with pl_wr_en low) to valid pl_dout. Legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A has an access pending.
- a_we  in  1  1 = write, 0 = read; qualified by a_req.
- a_addr  in  ADDR_W  requester A address.
- a_wdata  in  DATA_W  requester A write data.
- a_gnt  out  1  combinational; access accepted this cycle when a_req & a_gnt.
- a_rvalid  out  1  one-cycle pulse; a_rdata is valid.
- a_rdata  out  DATA_W  read data returned to A.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B.
- pl_addr  out  ADDR_W  BRAM address (registered).
- pl_en  out  1  BRAM enable (registered).
- pl_wr_en  out  1  BRAM write enable (registered).
- pl_din  out  DATA_W  BRAM write data (registered).
- pl_dout  in  DATA_W  BRAM read data.

Behaviour:
- Reset (async assert, sync release): all outputs 0; priority pointer = A; read-tag pipeline cleared.
- Grant is combinational from the requests and the pointer, at most one grant per cycle:
  - only one requester asserting req: that requester is granted;
  - both asserting: the requester at the pointer is granted.
- Pointer update: after an accepted access, the pointer moves to the other requester. With no acceptance, the pointer holds.
- A lone requester may be granted every cycle; full throughput is one access per clock.
- Accept at cycle N:
  - cycle N+1: pl_en = 1, pl_wr_en = we, pl_addr = addr, pl_din = wdata (pl_din = 0 for reads);
  - cycle N+1 with no accept at N: pl_en = 0, pl_wr_en = 0; pl_addr and pl_din hold their previous values.
- Read return: a tag (valid, owner) enters a READ_LATENCY-deep shift pipeline at cycle N+1.
  - At cycle N+1+READ_LATENCY, pl_dout is registered into the owner's rdata.
  - The owner's rvalid pulses at cycle N+2+READ_LATENCY. Total latency from accept is READ_LATENCY+2 (3 at default).
- rdata holds its last value between pulses. The non-owner's rdata is unchanged.
- Back-to-back reads return in issue order, one per cycle. A and B rvalid are never both high in the same cycle.
- Writes produce no rvalid.
- Requesters hold req/we/addr/wdata stable until granted; the arbiter does not latch unaccepted requests.
- req dropped without a grant: no access occurs.
- Read-after-write to the same address, accepted in consecutive cycles: the read returns the new data. This relies on BRAM write-first mode; the arbiter does no forwarding.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset); the pointer returns to A.
- Address values pass through unmodified; the arbiter performs no address arithmetic or wrap.

Decomposition:
- Shared package (bram_pkg): ADDR_W/DATA_W defaults; the requester ID type (REQ_A = 0, REQ_B = 1); the maximum READ_LATENCY constant.
- One sub-module: bram_rd_tag_pipe.
  - Parameterised shift register of {valid, owner} tags, depth READ_LATENCY.
  - Async reset clears the tags.
- Grant logic, pointer and port registers live in the top level.

Test Plan:
- Reset then idle: rst pulse, no req for 10 cycles -> all outputs 0, pl_en never high.
- Lone A read stream: a_req = 1, a_we = 0, addrs 0,1,2,3 on successive accepts, BRAM preloaded with mem[i] = i+100 -> a_gnt high 4 cycles; pl_addr 0..3 from cycle 1; a_rvalid cycles 3..6 with a_rdata 100..103; b_rvalid stays 0.
- Contention: a_req = b_req = 1 continuously from reset -> grants alternate A, B, A, B; pl_en high every cycle; each requester gets exactly half of 20 accepts.
- Write then read: B writes 0xDEADBEEF @0x0010; next cycle A reads 0x0010 -> pl_wr_en = 1 then 0 on consecutive cycles; a_rvalid with a_rdata = 0xDEADBEEF 3 cycles after A's accept.
- Latency parameter: READ_LATENCY = 3, A read of @0xFFFF -> a_rvalid exactly 5 cycles after accept; pl_addr = 0xFFFF.
- Reset mid-flight: A read accepted, rst asserted the following cycle for 1 cycle -> no a_rvalid afterwards; next contended grant goes to A.
